// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, S-box tables and round helper functions shared by the encrypt and decrypt cores
package aes_pkg;
  localparam int NR = 10;
  localparam int NK = 4;
  typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;
  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // constant multiply built from an xtime chain; c selects which powers of two are summed
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? b : 8'h00);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [127:0] key_expand_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t = sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = get_byte(s, (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4));
    return o;
  endfunction
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[get_byte(s, i)];
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < NK; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(get_byte(s, 4*c + r), 4'he) ^ gmul(get_byte(s, 4*c + (r+1) % 4), 4'hb)
                              ^ gmul(get_byte(s, 4*c + (r+2) % 4), 4'hd) ^ gmul(get_byte(s, 4*c + (r+3) % 4), 4'h9);
    return o;
  endfunction
endpackage

// File: rtl/aes_128_decrypt_if.sv
// aes_128_decrypt_if: valid-in/valid-out block handshake between a requester and the decrypt core
interface aes_128_decrypt_if #(
  parameter int DATA_W = 128,
  parameter int KEY_L = 128
);
  logic valid_in;
  logic [KEY_L-1:0] cipher_key;
  logic [DATA_W-1:0] cipher_text;
  logic ready;
  logic [DATA_W-1:0] plain_text;
  logic valid_out;
  modport master(output valid_in, cipher_key, cipher_text, input ready, plain_text, valid_out);
  modport slave(input valid_in, cipher_key, cipher_text, output ready, plain_text, valid_out);
endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round, MixColumns bypassed on the final round
module aes_inv_round import aes_pkg::*; (
  input logic [127:0] st,
  input logic [127:0] rk,
  input logic last,
  output logic [127:0] res
);
  logic [127:0] ark;
  assign ark = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
  assign res = last ? ark : inv_mix_columns(ark);
endmodule

// File: rtl/aes_128_decrypt.sv
// aes_128_decrypt: iterative AES-128 inverse cipher, forward key expansion then one inverse round per clock
module aes_128_decrypt import aes_pkg::*; #(
  parameter int DATA_W = 128,
  parameter int KEY_L = 128
) (
  input logic clk,
  input logic reset,
  aes_128_decrypt_if.slave bus
);
  state_t state;
  logic [3:0] ctr;
  logic [DATA_W-1:0] ct_reg, st, plain_text, round_out;
  logic [KEY_L-1:0] rk [0:NR];
  logic [KEY_L-1:0] next_key;
  logic valid_out;
  assign next_key = key_expand_round(rk[ctr - 4'd1], RCON[ctr - 4'd1]);
  assign bus.ready = (state == IDLE);
  assign bus.plain_text = plain_text;
  assign bus.valid_out = valid_out;
  aes_inv_round u_round (.st(st), .rk(rk[ctr]), .last(ctr == 4'd0), .res(round_out));
  // ctr counts key-expansion steps up in KEXP, then serves as the round index counting down in ROUND
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ctr <= '0;
      ct_reg <= '0;
      st <= '0;
      plain_text <= '0;
      valid_out <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: if (bus.valid_in) begin
          ct_reg <= bus.cipher_text;
          rk[0] <= bus.cipher_key;
          ctr <= 4'd1;
          state <= KEXP;
        end
        KEXP: begin
          rk[ctr] <= next_key;
          if (ctr == 4'(NR)) begin
            st <= ct_reg ^ next_key;
            ctr <= 4'(NR - 1);
            state <= ROUND;
          end else ctr <= ctr + 4'd1;
        end
        ROUND: if (ctr == 4'd0) begin
          plain_text <= round_out;
          valid_out <= 1'b1;
          state <= IDLE;
        end else begin
          st <= round_out;
          ctr <= ctr - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_128_decrypt.sv
// tb_aes_128_decrypt: FIPS vectors, handshake corner cases and random loopback against a byte-level AES model
module tb_aes_128_decrypt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  aes_128_decrypt_if bus ();
  aes_128_decrypt dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { logic [127:0] key, ct, pt; } vec_t;
  vec_t vecs [3];
  logic [7:0] sb [256];
  int n_cmp = 0, n_fail = 0, lat, pulses;
  logic [127:0] k, p;
  function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, y;
    r = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction
  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc;
    logic [31:0] x;
    logic [127:0] o;
    rc = 8'h01;
    o = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rc, 24'h0};
        rc = gf(rc, 8'h02);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c+j] = (r == 10) ? t[4*c+j] : gf(t[4*c+j], 8'h02) ^ gf(t[4*c+(j+1)%4], 8'h03) ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] key, input logic [127:0] ct);
    bus.valid_in = 1'b1;
    bus.cipher_key = key;
    bus.cipher_text = ct;
    tick();
    bus.valid_in = 1'b0;
  endtask
  task automatic wait_done(input int start, output int n);
    n = start;
    while (!bus.valid_out && n < 60) begin
      tick();
      n++;
    end
  endtask
  initial begin
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gf(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    bus.valid_in = 1'b0;
    bus.cipher_key = '0;
    bus.cipher_text = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_ready", 128'(bus.ready), 128'd1);
    check("reset_valid_out", 128'(bus.valid_out), 128'd0);
    check("reset_plain_text", bus.plain_text, 128'd0);
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].key, vecs[i].ct);
      wait_done(0, lat);
      check($sformatf("vec%0d_pt", i), bus.plain_text, vecs[i].pt);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd20);
      if (i == 1) check("vecB_rk10", dut.rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      tick();
      check($sformatf("vec%0d_pulse_width", i), 128'(bus.valid_out), 128'd0);
    end
    send(vecs[0].key, vecs[0].ct);
    repeat (4) tick();
    check("busy_ready", 128'(bus.ready), 128'd0);
    send(128'hdeadbeef, 128'hfeedface);
    wait_done(5, lat);
    check("busy_pt", bus.plain_text, vecs[0].pt);
    check("busy_latency", 128'(lat), 128'd20);
    check("b2b_ready", 128'(bus.ready), 128'd1);
    send(vecs[1].key, vecs[1].ct);
    wait_done(0, lat);
    check("b2b_gap", 128'(lat + 1), 128'd21);
    check("b2b_pt", bus.plain_text, vecs[1].pt);
    tick();
    send(vecs[0].key, vecs[0].ct);
    repeat (13) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready", 128'(bus.ready), 128'd1);
    check("midrst_plain_text", bus.plain_text, 128'd0);
    pulses = 0;
    repeat (25) begin
      pulses += int'(bus.valid_out);
      tick();
    end
    check("midrst_no_valid_out", 128'(pulses), 128'd0);
    send(vecs[0].key, vecs[0].ct);
    wait_done(0, lat);
    check("after_rst_pt", bus.plain_text, vecs[0].pt);
    check("after_rst_latency", 128'(lat), 128'd20);
    tick();
    reset = 1'b1;
    send(vecs[1].key, vecs[1].ct);
    reset = 1'b0;
    check("rst_vs_valid_ready", 128'(bus.ready), 128'd1);
    pulses = 0;
    repeat (25) begin
      pulses += int'(bus.valid_out);
      tick();
    end
    check("rst_vs_valid_no_out", 128'(pulses), 128'd0);
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      send(k, enc(k, p));
      wait_done(0, lat);
      check($sformatf("loop%0d_pt", i), bus.plain_text, p);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_128_decrypt.md
# aes_128_decrypt

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that recovers plaintext from a 128-bit ciphertext block under a 128-bit cipher key. It is the receive-side counterpart of the AES-128 encryption core and shares that core's data/key widths and valid-in/valid-out handshake. The block expands the key forward, storing all round keys, then applies one inverse round per clock. Fixed latency is 20 cycles, and one block is in flight at a time.

## Interface
- DATA_W, 128, block width; only 128 is supported
- KEY_L, 128, key width; only 128 is supported
- clk  input  1  system clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  key and ciphertext valid; sampled only while ready=1
- cipher_key  input  KEY_L  cipher key (the same key that was used for encryption)
- cipher_text  input  DATA_W  ciphertext block
- ready  output  1  block idle and able to accept; reset value 1
- plain_text  output  DATA_W  recovered plaintext, registered; reset value 0
- valid_out  output  1  one-cycle pulse marking plain_text valid; reset value 0

## Operation
- Byte order: bits [127:120] are FIPS byte 0. The state is column-major; bytes 0..3 form column 0. The same order applies to the key.
- States are IDLE, KEXP and ROUND. ready = (state == IDLE).
- IDLE: on valid_in=1, latch cipher_text into ct_reg and cipher_key into rk[0]. Set ctr=1 and go to KEXP. valid_in while ready=0 is ignored and not queued.
- KEXP, ctr=1..10, one cycle each: rk[ctr] <= KeyExpand(rk[ctr-1], Rcon[ctr]), with Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - At ctr=10, also load st <= ct_reg ^ next_key (that is, rk[10]).
  - Then go to ROUND with r=9.
- ROUND, r=9 down to 1: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[r]).
- ROUND, r=0: plain_text <= InvSubBytes(InvShiftRows(st)) ^ rk[0]. InvMixColumns is skipped. Set valid_out=1 for the next cycle and go to IDLE.
- GF(2^8) arithmetic uses the polynomial 0x11b. InvMixColumns coefficients are 0e,0b,0d,09, implemented with xtime chains. No multipliers.
- plain_text holds its value until the next completion. A new input never corrupts it mid-flight.
- Reset at any point:
  - state goes to IDLE; valid_out, plain_text, st, ct_reg and all rk[] are cleared to 0. Key material is not retained.
  - A block in progress is discarded and produces no valid_out.
- reset asserted in the same cycle as valid_in: reset wins and nothing is accepted.

## Timing
- Acceptance edge T0 is the edge where valid_in=1 and ready=1. ready is 0 from the cycle after T0.
- KEXP occupies edges T1..T10. ROUND occupies edges T11..T20.
- At T20, plain_text is loaded and valid_out rises. valid_out is high for exactly the cycle after T20.
- ready=1 in that same cycle. A valid_in there is accepted (back-to-back operation), so throughput is one block per 21 cycles.
- Latency from valid_in sampled to the valid_out cycle is 20 clocks, independent of the data.

## Structure
- Shared package aes_pkg, reused by the encrypt core, contains:
  - constants NR=10 and NK=4;
  - the Rcon array;
  - the forward S-box table (needed for key expansion) and the inverse S-box table;
  - functions xtime, gmul for 09/0b/0d/0e, sub_word, rot_word, key_expand_round, inv_shift_rows and inv_mix_columns.
- One natural sub-module, aes_inv_round: a combinational unit with inputs st, rk and last. Its output is InvShiftRows → InvSubBytes → AddRoundKey, followed by InvMixColumns unless last=1.
- Top level holds the FSM, ctr/r counter, ct_reg, rk[0:10] and output registers.

## Test plan
- FIPS-197 C.1:
  - key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff.
  - valid_out is high exactly 20 clocks after valid_in, for 1 cycle.
- FIPS-197 B:
  - key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734.
  - Also check internal rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e → pt 0.
  - Also check the reset values: ready=1, valid_out=0, plain_text=0.
- Busy and back-to-back:
  - Pulse valid_in with garbage data at T5 → ignored, and the C.1 result is unchanged.
  - Assert valid_in with the B vectors in the valid_out cycle → accepted; the second valid_out comes 21 cycles after the first.
- Reset mid-operation:
  - Assert reset during ROUND → no valid_out, plain_text=0, ready=1 next cycle.
  - A subsequent C.1 run gives the correct result.
- Random loopback: 1000 random key/pt pairs encrypted by the encrypt core and fed to this block → plaintext recovered exactly.
